fport_frame_parser: RTL and testbench
=====================================

FPORT_FRAME_PARSER -- requirements
Module: fport_frame_parser

Interface
REQ-001 SHALL have parameter BASE_FREQ, default 16_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 500, maximum inter-byte gap inside a frame, in microseconds.
REQ-003 SHALL have ports: clock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have ports: reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports: rxDataReady, input, 1, one-clock strobe from uart_rx marking a received byte.
REQ-006 SHALL have ports: rxData, input, 8, received byte, valid when rxDataReady=1.
REQ-007 SHALL have ports: channels, output, 176, 16 channels x 11 bits; channel i at bits [11i+10:11i].
REQ-008 SHALL have ports: rssi, output, 8, RSSI byte of the last good frame.
REQ-009 SHALL have ports: failsafe, output, 1, flags bit 3 of the last good frame.
REQ-010 SHALL have ports: frameLost, output, 1, flags bit 2 of the last good frame.
REQ-011 SHALL have ports: frameValid, output, 1, one-clock pulse when outputs update.
REQ-012 SHALL have ports: errCount, output, 8, saturating count of rejected frames.

Function
REQ-013 SHALL implement states IDLE, LEN, TYPE, DATA, FLAGS, RSSI, CRC, END.
REQ-014 SHALL leave IDLE only on unescaped 0x7E; consecutive 0x7E bytes keep it in LEN.
REQ-015 SHALL unstuff: 0x7D is discarded and the next byte is XORed with 0x20 before use.
REQ-016 SHALL, in LEN, accept only 0x19; any other value -> IDLE, errCount+1.
REQ-017 SHALL, in TYPE, accept only 0x00 (control); other types -> IDLE without error count.
REQ-018 SHALL, in DATA, take 22 bytes, shifting each into a 176-bit register as {byte, reg[175:8]}, so the stream unpacks LSB-first.
REQ-019 SHALL keep an 8-bit one's-complement sum (carry folded back each add) over LEN..RSSI bytes after unstuffing.
REQ-020 SHALL, in CRC, require sum + crc byte (folded) == 0xFF; on mismatch -> IDLE, errCount+1.
REQ-021 SHALL, in END, require an unescaped 0x7E; on success, update channels/rssi/failsafe/frameLost and pulse frameValid the next clock, then go to LEN; otherwise -> IDLE, errCount+1.
REQ-022 SHALL treat an unescaped 0x7E received in TYPE..CRC as a new frame start: errCount+1, go to LEN.
REQ-023 SHALL count clocks since the last byte while outside IDLE; at BASE_FREQ/1_000_000*TIMEOUT_US clocks -> IDLE, errCount+1.
REQ-024 SHALL hold errCount at 255 once reached.
REQ-025 SHALL keep outputs unchanged on any rejected or partial frame.
REQ-026 SHALL accept a new byte every clock (no backpressure; input bytes are never dropped).

Reset
REQ-027 SHALL, on reset assertion, go to IDLE immediately and clear the escape flag, the sum, and the timeout counter.
REQ-028 SHALL reset channels to 0, rssi to 0, failsafe to 1, frameLost to 1, frameValid to 0, and errCount to 0.
REQ-029 SHALL discard a frame in progress at reset; bytes are not accepted while reset is high.

Structure
REQ-030 SHALL take FPORT_DELIM=0x7E, FPORT_ESC=0x7D, FPORT_XOR=0x20, FPORT_LEN_CTRL=0x19, FPORT_TYPE_CTRL=0x00, FPORT_CHANNELS=16, FPORT_CH_BITS=11, and the state encoding from shared package fport_pkg.
REQ-031 SHALL contain one sub-module, fport_unstuff, which performs escape removal and marks unescaped delimiters; the remaining logic stays flat.

Verification
REQ-032 SHALL cover a good control frame with all channels = 992 (0x3E0), flags 0x00, rssi 0x64 -> one frameValid pulse, each channel 992, rssi 100, failsafe 0, errCount 0.
REQ-033 SHALL cover a data byte of 0x7E sent as 0x7D 0x5E, with a correct CRC -> frame accepted, unpacked value matches.
REQ-034 SHALL cover a correct frame with the CRC byte inverted -> no frameValid, outputs unchanged, errCount 1.
REQ-035 SHALL cover a frame stopped after 10 DATA bytes for 2xTIMEOUT_US, then a good frame -> errCount 1, second frame accepted.
REQ-036 SHALL cover flags 0x08 -> failsafe 1, frameLost 0, frameValid pulses.
REQ-037 SHALL cover reset asserted mid-DATA, then a full good frame -> outputs at reset values until that frame, then updated; errCount 0.

Source files
------------

// File: rtl/fport_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the F.Port receive path.
package fport_pkg;

  localparam logic [7:0] FPORT_DELIM     = 8'h7E;
  localparam logic [7:0] FPORT_ESC       = 8'h7D;
  localparam logic [7:0] FPORT_XOR       = 8'h20;
  localparam logic [7:0] FPORT_LEN_CTRL  = 8'h19;
  localparam logic [7:0] FPORT_TYPE_CTRL = 8'h00;
  localparam int         FPORT_CHANNELS  = 16;
  localparam int         FPORT_CH_BITS   = 11;
  localparam int         FPORT_DATA_BITS = FPORT_CHANNELS * FPORT_CH_BITS;
  localparam int         FPORT_DATA_BYTES = FPORT_DATA_BITS / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_TYPE,
    ST_DATA,
    ST_FLAGS,
    ST_RSSI,
    ST_CRC,
    ST_END
  } fport_state_t;

  // 8-bit one's-complement add: the carry out is folded back into bit 0.
  function automatic logic [7:0] ones_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fport_unstuff.sv
// Byte-stuffing removal: drops 0x7D, XORs the following byte with 0x20, and
// flags 0x7E bytes that arrived unescaped (frame delimiters).
module fport_unstuff
  import fport_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_delim
);

  logic esc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      esc <= 1'b0;
    end else if (clear) begin
      esc <= 1'b0;
    end else if (in_valid) begin
      esc <= !esc && (in_data == FPORT_ESC);
    end
  end

  always_comb begin
    out_valid = in_valid && (esc || (in_data != FPORT_ESC));
    out_data  = esc ? (in_data ^ FPORT_XOR) : in_data;
    out_delim = out_valid && !esc && (in_data == FPORT_DELIM);
  end

endmodule

// File: rtl/fport_frame_parser.sv
// F.Port control-frame parser: validates length/type/checksum and publishes
// 16 x 11-bit channels, RSSI and flags once per good frame.
module fport_frame_parser
  import fport_pkg::*;
#(
  parameter int BASE_FREQ  = 16_000_000,
  parameter int TIMEOUT_US = 500
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rxDataReady,
  input  logic [7:0]                 rxData,
  output logic [FPORT_DATA_BITS-1:0] channels,
  output logic [7:0]                 rssi,
  output logic                       failsafe,
  output logic                       frameLost,
  output logic                       frameValid,
  output logic [7:0]                 errCount,
  output fport_state_t               state
);

  // Handshake: rxDataReady is a one-cycle strobe qualifying rxData. There is no
  // ready back to the source; every strobed byte is consumed on that clock.

  localparam int TIMEOUT_CLKS = BASE_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

  logic                       b_valid;
  logic [7:0]                 b_data;
  logic                       b_delim;
  logic [TW-1:0]              tmo_cnt;
  logic                       tmo_hit;
  logic [FPORT_DATA_BITS-1:0] shift_q;
  logic [7:0]                 sum_q;
  logic [7:0]                 rssi_q;
  logic                       fs_q;
  logic                       fl_q;
  logic [4:0]                 data_cnt;

  assign tmo_hit = (state != ST_IDLE) && !rxDataReady &&
                   (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

  fport_unstuff u_unstuff (
    .clock     (clock),
    .reset     (reset),
    .clear     (tmo_hit),
    .in_valid  (rxDataReady),
    .in_data   (rxData),
    .out_valid (b_valid),
    .out_data  (b_data),
    .out_delim (b_delim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      sum_q      <= 8'd0;
      shift_q    <= '0;
      rssi_q     <= 8'd0;
      fs_q       <= 1'b0;
      fl_q       <= 1'b0;
      data_cnt   <= 5'd0;
      channels   <= '0;
      rssi       <= 8'd0;
      failsafe   <= 1'b1;
      frameLost  <= 1'b1;
      frameValid <= 1'b0;
      errCount   <= 8'd0;
    end else begin
      frameValid <= 1'b0;
      // Raw bytes (escapes included) restart the inter-byte gap timer.
      if (rxDataReady || state == ST_IDLE || tmo_hit) tmo_cnt <= '0;
      else                                            tmo_cnt <= tmo_cnt + 1'b1;

      if (tmo_hit) begin
        state    <= ST_IDLE;
        errCount <= sat_inc(errCount);
      end else if (b_valid) begin
        if (b_delim && (state inside {ST_TYPE, ST_DATA, ST_FLAGS, ST_RSSI, ST_CRC})) begin
          state    <= ST_LEN;
          errCount <= sat_inc(errCount);
        end else begin
          case (state)
            ST_IDLE: if (b_delim) state <= ST_LEN;
            ST_LEN: begin
              if (b_delim) begin
                state <= ST_LEN;
              end else if (b_data == FPORT_LEN_CTRL) begin
                state <= ST_TYPE;
                sum_q <= b_data;
              end else begin
                state    <= ST_IDLE;
                errCount <= sat_inc(errCount);
              end
            end
            ST_TYPE: begin
              if (b_data == FPORT_TYPE_CTRL) begin
                state    <= ST_DATA;
                sum_q    <= ones_add(sum_q, b_data);
                data_cnt <= 5'd0;
              end else begin
                state <= ST_IDLE;
              end
            end
            ST_DATA: begin
              shift_q  <= {b_data, shift_q[FPORT_DATA_BITS-1:8]};
              sum_q    <= ones_add(sum_q, b_data);
              data_cnt <= data_cnt + 5'd1;
              if (data_cnt == 5'(FPORT_DATA_BYTES - 1)) state <= ST_FLAGS;
            end
            ST_FLAGS: begin
              fs_q  <= b_data[3];
              fl_q  <= b_data[2];
              sum_q <= ones_add(sum_q, b_data);
              state <= ST_RSSI;
            end
            ST_RSSI: begin
              rssi_q <= b_data;
              sum_q  <= ones_add(sum_q, b_data);
              state  <= ST_CRC;
            end
            ST_CRC: begin
              if (ones_add(sum_q, b_data) == 8'hFF) begin
                state <= ST_END;
              end else begin
                state    <= ST_IDLE;
                errCount <= sat_inc(errCount);
              end
            end
            ST_END: begin
              if (b_delim) begin
                channels   <= shift_q;
                rssi       <= rssi_q;
                failsafe   <= fs_q;
                frameLost  <= fl_q;
                frameValid <= 1'b1;
                state      <= ST_LEN;
              end else begin
                state    <= ST_IDLE;
                errCount <= sat_inc(errCount);
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fport_frame_parser.sv
// Directed bench for fport_frame_parser: good, escaped, corrupt, timed-out,
// interrupted and back-to-back frames against hand-built expectations.
module tb_fport_frame_parser;
  import fport_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         rxDataReady;
  logic [7:0]   rxData;
  logic [175:0] channels;
  logic [7:0]   rssi;
  logic         failsafe;
  logic         frameLost;
  logic         frameValid;
  logic [7:0]   errCount;
  fport_state_t state;

  int vectors = 0;
  int miscompares = 0;
  int fv_total = 0;

  localparam int TIMEOUT_CLKS = 16_000_000 / 1_000_000 * 500;

  fport_frame_parser #(.BASE_FREQ(16_000_000), .TIMEOUT_US(500)) dut (
    .clock       (clock),
    .reset       (reset),
    .rxDataReady (rxDataReady),
    .rxData      (rxData),
    .channels    (channels),
    .rssi        (rssi),
    .failsafe    (failsafe),
    .frameLost   (frameLost),
    .frameValid  (frameValid),
    .errCount    (errCount),
    .state       (state)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frameValid === 1'b1) fv_total++;

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    rxDataReady = 1'b0;
    rxData = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_raw(input logic [7:0] b);
    @(negedge clock);
    rxDataReady = 1'b1;
    rxData = b;
  endtask

  task automatic send_stuffed(input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7D) begin
      send_raw(8'h7D);
      send_raw(b ^ 8'h20);
    end else begin
      send_raw(b);
    end
  endtask

  task automatic idle_bus(input int n);
    repeat (n) begin
      @(negedge clock);
      rxDataReady = 1'b0;
    end
  endtask

  // Builds checksum from scratch: plain integer sum, folded at the end.
  task automatic send_frame(input logic [175:0] data, input logic [7:0] flags,
                            input logic [7:0] rssi_b, input bit bad_crc);
    int sum;
    logic [7:0] crc;
    sum = 8'h19 + 8'h00 + int'(flags) + int'(rssi_b);
    for (int k = 0; k < 22; k++) sum += int'(data[8*k +: 8]);
    while (sum > 255) sum = (sum & 255) + (sum >> 8);
    crc = 8'hFF - 8'(sum);
    if (bad_crc) crc = ~crc;
    send_raw(8'h7E);
    send_stuffed(8'h19);
    send_stuffed(8'h00);
    for (int k = 0; k < 22; k++) send_stuffed(data[8*k +: 8]);
    send_stuffed(flags);
    send_stuffed(rssi_b);
    send_stuffed(crc);
    send_raw(8'h7E);
  endtask

  function automatic logic [175:0] all_ch(input logic [10:0] v);
    logic [175:0] r;
    for (int i = 0; i < 16; i++) r[11*i +: 11] = v;
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; rxDataReady = 1'b0; rxData = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    vectors++; if (channels !== 176'd0) begin miscompares++; $display("FAIL reset_channels: got %h want 0", channels); end
    vectors++; if (rssi !== 8'd0) begin miscompares++; $display("FAIL reset_rssi: got %0d want 0", rssi); end
    vectors++; if (failsafe !== 1'b1) begin miscompares++; $display("FAIL reset_failsafe: got %b want 1", failsafe); end
    vectors++; if (frameLost !== 1'b1) begin miscompares++; $display("FAIL reset_frameLost: got %b want 1", frameLost); end
    vectors++; if (frameValid !== 1'b0) begin miscompares++; $display("FAIL reset_frameValid: got %b want 0", frameValid); end
    vectors++; if (errCount !== 8'd0) begin miscompares++; $display("FAIL reset_errCount: got %0d want 0", errCount); end
    vectors++; if (state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
  endtask

  task automatic test_good_frame();
    int fv0;
    fv0 = fv_total;
    send_frame(all_ch(11'd992), 8'h00, 8'h64, 1'b0);
    idle_bus(4);
    vectors++; if (fv_total - fv0 != 1) begin miscompares++; $display("FAIL good_pulses: got %0d want 1", fv_total - fv0); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (channels[11*i +: 11] !== 11'd992) begin miscompares++; $display("FAIL good_ch%0d: got %0d want 992", i, channels[11*i +: 11]); end
    end
    vectors++; if (rssi !== 8'd100) begin miscompares++; $display("FAIL good_rssi: got %0d want 100", rssi); end
    vectors++; if (failsafe !== 1'b0) begin miscompares++; $display("FAIL good_failsafe: got %b want 0", failsafe); end
    vectors++; if (frameLost !== 1'b0) begin miscompares++; $display("FAIL good_frameLost: got %b want 0", frameLost); end
    vectors++; if (errCount !== 8'd0) begin miscompares++; $display("FAIL good_errCount: got %0d want 0", errCount); end
  endtask

  // Channel 0 = 0x07E puts 0x7E in the first data byte; rssi 0x7D needs escaping too.
  logic [175:0] esc_vec;
  task automatic test_escaped_data();
    int fv0;
    esc_vec[10:0]  = 11'h07E;
    esc_vec[21:11] = 11'h7FF;
    esc_vec[32:22] = 11'h000;
    for (int i = 3; i < 16; i++) esc_vec[11*i +: 11] = 11'(i * 100);
    fv0 = fv_total;
    send_frame(esc_vec, 8'h04, 8'h7D, 1'b0);
    idle_bus(4);
    vectors++; if (fv_total - fv0 != 1) begin miscompares++; $display("FAIL esc_pulses: got %0d want 1", fv_total - fv0); end
    vectors++; if (channels !== esc_vec) begin miscompares++; $display("FAIL esc_channels: got %h want %h", channels, esc_vec); end
    vectors++; if (channels[10:0] !== 11'h07E) begin miscompares++; $display("FAIL esc_ch0: got %h want 07e", channels[10:0]); end
    vectors++; if (rssi !== 8'h7D) begin miscompares++; $display("FAIL esc_rssi: got %h want 7d", rssi); end
    vectors++; if (frameLost !== 1'b1 || failsafe !== 1'b0) begin miscompares++; $display("FAIL esc_flags: got fs=%b fl=%b want fs=0 fl=1", failsafe, frameLost); end
    vectors++; if (errCount !== 8'd0) begin miscompares++; $display("FAIL esc_errCount: got %0d want 0", errCount); end
  endtask

  task automatic test_bad_crc();
    int fv0;
    fv0 = fv_total;
    send_frame(all_ch(11'd992), 8'h00, 8'h64, 1'b1);
    idle_bus(4);
    vectors++; if (fv_total - fv0 != 0) begin miscompares++; $display("FAIL badcrc_pulses: got %0d want 0", fv_total - fv0); end
    vectors++; if (channels !== esc_vec) begin miscompares++; $display("FAIL badcrc_channels: got %h want %h", channels, esc_vec); end
    vectors++; if (rssi !== 8'h7D) begin miscompares++; $display("FAIL badcrc_rssi: got %h want 7d", rssi); end
    vectors++; if (frameLost !== 1'b1) begin miscompares++; $display("FAIL badcrc_frameLost: got %b want 1", frameLost); end
    vectors++; if (errCount !== 8'd1) begin miscompares++; $display("FAIL badcrc_errCount: got %0d want 1", errCount); end
  endtask

  task automatic test_timeout();
    int fv0;
    logic [175:0] v;
    for (int i = 0; i < 16; i++) v[11*i +: 11] = 11'(i * 37 + 5);
    apply_reset();
    send_raw(8'h7E); send_raw(8'h19); send_raw(8'h00);
    for (int k = 0; k < 10; k++) send_stuffed(v[8*k +: 8]);
    idle_bus(2);
    vectors++; if (state !== ST_DATA) begin miscompares++; $display("FAIL tmo_state_pre: got %0d want %0d", state, ST_DATA); end
    idle_bus(2 * TIMEOUT_CLKS);
    vectors++; if (errCount !== 8'd1) begin miscompares++; $display("FAIL tmo_errCount: got %0d want 1", errCount); end
    vectors++; if (state !== ST_IDLE) begin miscompares++; $display("FAIL tmo_state: got %0d want %0d", state, ST_IDLE); end
    vectors++; if (channels !== 176'd0) begin miscompares++; $display("FAIL tmo_channels: got %h want 0", channels); end
    fv0 = fv_total;
    send_frame(v, 8'h00, 8'h55, 1'b0);
    idle_bus(4);
    vectors++; if (fv_total - fv0 != 1) begin miscompares++; $display("FAIL tmo_next_pulses: got %0d want 1", fv_total - fv0); end
    vectors++; if (channels !== v) begin miscompares++; $display("FAIL tmo_next_channels: got %h want %h", channels, v); end
    vectors++; if (rssi !== 8'h55) begin miscompares++; $display("FAIL tmo_next_rssi: got %h want 55", rssi); end
    vectors++; if (errCount !== 8'd1) begin miscompares++; $display("FAIL tmo_next_errCount: got %0d want 1", errCount); end
  endtask

  task automatic test_failsafe_flags();
    int fv0;
    fv0 = fv_total;
    send_frame(all_ch(11'd172), 8'h08, 8'h20, 1'b0);
    idle_bus(4);
    vectors++; if (fv_total - fv0 != 1) begin miscompares++; $display("FAIL fs_pulses: got %0d want 1", fv_total - fv0); end
    vectors++; if (failsafe !== 1'b1) begin miscompares++; $display("FAIL fs_failsafe: got %b want 1", failsafe); end
    vectors++; if (frameLost !== 1'b0) begin miscompares++; $display("FAIL fs_frameLost: got %b want 0", frameLost); end
    vectors++; if (channels !== all_ch(11'd172)) begin miscompares++; $display("FAIL fs_channels: got %h", channels); end
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    apply_reset();
    send_raw(8'h7E); send_raw(8'h19); send_raw(8'h00);
    for (int k = 0; k < 5; k++) send_raw(8'hA5);
    @(negedge clock);
    rxDataReady = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle_bus(4);
    vectors++; if (state !== ST_IDLE) begin miscompares++; $display("FAIL rmid_state: got %0d want %0d", state, ST_IDLE); end
    vectors++; if (channels !== 176'd0 || rssi !== 8'd0) begin miscompares++; $display("FAIL rmid_outputs: got rssi=%0d ch=%h want 0", rssi, channels); end
    vectors++; if (failsafe !== 1'b1 || frameLost !== 1'b1) begin miscompares++; $display("FAIL rmid_flags: got fs=%b fl=%b want 1 1", failsafe, frameLost); end
    fv0 = fv_total;
    send_frame(all_ch(11'd1811), 8'h00, 8'h3C, 1'b0);
    idle_bus(4);
    vectors++; if (fv_total - fv0 != 1) begin miscompares++; $display("FAIL rmid_pulses: got %0d want 1", fv_total - fv0); end
    vectors++; if (channels !== all_ch(11'd1811)) begin miscompares++; $display("FAIL rmid_channels: got %h", channels); end
    vectors++; if (rssi !== 8'h3C) begin miscompares++; $display("FAIL rmid_rssi: got %h want 3c", rssi); end
    vectors++; if (errCount !== 8'd0) begin miscompares++; $display("FAIL rmid_errCount: got %0d want 0", errCount); end
  endtask

  task automatic test_len_type();
    apply_reset();
    send_raw(8'h7D); send_raw(8'h5E); send_raw(8'h19);
    idle_bus(2);
    vectors++; if (state !== ST_IDLE) begin miscompares++; $display("FAIL escdelim_state: got %0d want %0d", state, ST_IDLE); end
    send_raw(8'h7E); send_raw(8'h18);
    idle_bus(2);
    vectors++; if (errCount !== 8'd1) begin miscompares++; $display("FAIL badlen_errCount: got %0d want 1", errCount); end
    send_raw(8'h7E); send_raw(8'h19); send_raw(8'h01);
    idle_bus(2);
    vectors++; if (errCount !== 8'd1 || state !== ST_IDLE) begin miscompares++; $display("FAIL badtype: got err=%0d st=%0d want 1 %0d", errCount, state, ST_IDLE); end
    send_raw(8'h7E); send_raw(8'h7E); send_raw(8'h7E);
    idle_bus(2);
    vectors++; if (state !== ST_LEN) begin miscompares++; $display("FAIL multidelim_state: got %0d want %0d", state, ST_LEN); end
    send_raw(8'h19); send_raw(8'h00); send_raw(8'h11); send_raw(8'h7E);
    idle_bus(2);
    vectors++; if (errCount !== 8'd2 || state !== ST_LEN) begin miscompares++; $display("FAIL restart: got err=%0d st=%0d want 2 %0d", errCount, state, ST_LEN); end
  endtask

  task automatic test_back_to_back();
    int fv0;
    fv0 = fv_total;
    send_frame(all_ch(11'd300), 8'h00, 8'h10, 1'b0);
    send_frame(all_ch(11'd1500), 8'h0C, 8'h20, 1'b0);
    idle_bus(4);
    vectors++; if (fv_total - fv0 != 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 2", fv_total - fv0); end
    vectors++; if (channels !== all_ch(11'd1500)) begin miscompares++; $display("FAIL b2b_channels: got %h", channels); end
    vectors++; if (failsafe !== 1'b1 || frameLost !== 1'b1) begin miscompares++; $display("FAIL b2b_flags: got fs=%b fl=%b want 1 1", failsafe, frameLost); end
    vectors++; if (errCount !== 8'd2) begin miscompares++; $display("FAIL b2b_errCount: got %0d want 2", errCount); end
  endtask

  task automatic test_err_saturate();
    apply_reset();
    for (int n = 0; n < 260; n++) begin
      send_raw(8'h7E);
      send_raw(8'h18);
    end
    idle_bus(2);
    vectors++; if (errCount !== 8'd255) begin miscompares++; $display("FAIL sat_errCount: got %0d want 255", errCount); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_escaped_data();
    test_bad_crc();
    test_timeout();
    test_failsafe_flags();
    test_reset_mid_frame();
    test_len_type();
    test_back_to_back();
    test_err_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
